// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures decode-stage control and datapath fields for execute.
// Inserts a one-cycle bubble on a load-use hazard and clears on a branch/jump flush.
// Holds its contents while execute back-pressures.
// Keeps saturating stall and flush event counters for debug.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  id_ctrl,
  input  logic [5:0]  id_xflags,
  input  logic        id_valid,
  input  logic [31:0] id_pc4,
  input  logic [31:0] id_rdata1,
  input  logic [31:0] id_rdata2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        ex_flush,
  input  logic        ex_ready,
  output logic [8:0]  ex_ctrl,
  output logic [5:0]  ex_xflags,
  output logic        ex_valid,
  output logic [31:0] ex_pc4,
  output logic [31:0] ex_rdata1,
  output logic [31:0] ex_rdata2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic        stall_o,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  ctrl_q, ctrl_d;
  logic [5:0]  xflags_q, xflags_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic [31:0] rdata2_q, rdata2_d;
  logic [31:0] imm_q, imm_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [4:0]  rd_q, rd_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic        load_use;
  logic        do_load;
  logic        do_bubble;

  // The rt match is made conservatively even when the decode instruction does not read rt.
  assign load_use  = id_valid & (state_q == FULL) & ctrl_q[5] & (rt_q != 5'd0) &
                     ((rt_q == id_rs) | (rt_q == id_rt));
  assign stall_o   = (load_use | ~ex_ready) & ~ex_flush;
  assign do_bubble = ~ex_flush & ex_ready & load_use;
  assign do_load   = ~ex_flush & ex_ready & ~load_use;

  // Occupancy: flush beats hold, hold beats bubble, bubble beats load.
  always_comb begin
    state_d = state_q;
    if (ex_flush) begin
      state_d = EMPTY;
    end else if (!ex_ready) begin
      state_d = state_q;
    end else if (load_use) begin
      state_d = EMPTY;
    end else begin
      state_d = id_valid ? FULL : EMPTY;
    end
  end

  // Control is zeroed whenever the slot is empty so a bubble can never write or branch.
  always_comb begin
    ctrl_d   = ctrl_q;
    xflags_d = xflags_q;
    if (ex_flush || do_bubble) begin
      ctrl_d   = 9'd0;
      xflags_d = 6'd0;
    end else if (do_load) begin
      ctrl_d   = id_valid ? id_ctrl   : 9'd0;
      xflags_d = id_valid ? id_xflags : 6'd0;
    end
  end

  // Datapath fields only move on a load; flushes and bubbles leave them in place.
  always_comb begin
    pc4_d    = pc4_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    imm_d    = imm_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    if (do_load) begin
      pc4_d    = id_pc4;
      rdata1_d = id_rdata1;
      rdata2_d = id_rdata2;
      imm_d    = id_imm;
      rs_d     = id_rs;
      rt_d     = id_rt;
      rd_d     = id_rd;
    end
  end

  // Saturating debug counters; flushes count even while execute is holding.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (do_bubble && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (ex_flush && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // State, pipeline and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      ctrl_q      <= 9'd0;
      xflags_q    <= 6'd0;
      pc4_q       <= 32'd0;
      rdata1_q    <= 32'd0;
      rdata2_q    <= 32'd0;
      imm_q       <= 32'd0;
      rs_q        <= 5'd0;
      rt_q        <= 5'd0;
      rd_q        <= 5'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      xflags_q    <= xflags_d;
      pc4_q       <= pc4_d;
      rdata1_q    <= rdata1_d;
      rdata2_q    <= rdata2_d;
      imm_q       <= imm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_valid  = (state_q == FULL);
  assign ex_ctrl   = ctrl_q;
  assign ex_xflags = xflags_q;
  assign ex_pc4    = pc4_q;
  assign ex_rdata1 = rdata1_q;
  assign ex_rdata2 = rdata2_q;
  assign ex_imm    = imm_q;
  assign ex_rs     = rs_q;
  assign ex_rt     = rt_q;
  assign ex_rd     = rd_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage.
// Directed hazard, hold and flush scenarios, then randomized traffic with a mid-run reset.
// Ends with a flush counter saturation run, all checked against a transaction-level model.
module tb_id_ex_stage;

  logic        clk;
  logic        rstN;
  logic [8:0]  idCtrl;
  logic [5:0]  idXflags;
  logic        idValid;
  logic [31:0] idPc4, idRdata1, idRdata2, idImm;
  logic [4:0]  idRs, idRt, idRd;
  logic        exFlush, exReady;
  logic [8:0]  exCtrl;
  logic [5:0]  exXflags;
  logic        exValid;
  logic [31:0] exPc4, exRdata1, exRdata2, exImm;
  logic [4:0]  exRs, exRt, exRd;
  logic        stallO;
  logic [15:0] stallCnt, flushCnt;

  int compared;
  int mismatched;

  // The model's view of the ID/EX slot: one record plus two event counts.
  logic        mValid;
  logic [8:0]  mCtrl;
  logic [5:0]  mXflags;
  logic [31:0] mPc4, mRdata1, mRdata2, mImm;
  logic [4:0]  mRs, mRt, mRd;
  int          mStalls;
  int          mFlushes;

  id_ex_stage dut (
    .clk       (clk),
    .rst_n     (rstN),
    .id_ctrl   (idCtrl),
    .id_xflags (idXflags),
    .id_valid  (idValid),
    .id_pc4    (idPc4),
    .id_rdata1 (idRdata1),
    .id_rdata2 (idRdata2),
    .id_imm    (idImm),
    .id_rs     (idRs),
    .id_rt     (idRt),
    .id_rd     (idRd),
    .ex_flush  (exFlush),
    .ex_ready  (exReady),
    .ex_ctrl   (exCtrl),
    .ex_xflags (exXflags),
    .ex_valid  (exValid),
    .ex_pc4    (exPc4),
    .ex_rdata1 (exRdata1),
    .ex_rdata2 (exRdata2),
    .ex_imm    (exImm),
    .ex_rs     (exRs),
    .ex_rt     (exRt),
    .ex_rd     (exRd),
    .stall_o   (stallO),
    .stall_cnt (stallCnt),
    .flush_cnt (flushCnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic modelLoadUse();
    return idValid && mValid && mCtrl[5] && (mRt != 5'd0) && ((mRt == idRs) || (mRt == idRt));
  endfunction

  function automatic logic modelStall();
    return (modelLoadUse() || !exReady) && !exFlush;
  endfunction

  function automatic logic [15:0] sat16(input int n);
    return (n > 65535) ? 16'hFFFF : n[15:0];
  endfunction

  task automatic modelReset();
    mValid = 1'b0; mCtrl = '0; mXflags = '0;
    mPc4 = '0; mRdata1 = '0; mRdata2 = '0; mImm = '0;
    mRs = '0; mRt = '0; mRd = '0;
    mStalls = 0; mFlushes = 0;
  endtask

  task automatic modelEdge();
    logic lu;
    lu = modelLoadUse();
    if (exFlush) mFlushes++;
    if (exFlush) begin
      mValid = 1'b0; mCtrl = '0; mXflags = '0;
    end else if (exReady && lu) begin
      mValid = 1'b0; mCtrl = '0; mXflags = '0;
      mStalls++;
    end else if (exReady) begin
      mValid  = idValid;
      mCtrl   = idValid ? idCtrl : 9'd0;
      mXflags = idValid ? idXflags : 6'd0;
      mPc4 = idPc4; mRdata1 = idRdata1; mRdata2 = idRdata2; mImm = idImm;
      mRs = idRs; mRt = idRt; mRd = idRd;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_valid"},  exValid,  mValid);
    checkOutput({tag, "_ctrl"},   exCtrl,   mCtrl);
    checkOutput({tag, "_xflags"}, exXflags, mXflags);
    checkOutput({tag, "_pc4"},    exPc4,    mPc4);
    checkOutput({tag, "_rdata1"}, exRdata1, mRdata1);
    checkOutput({tag, "_rdata2"}, exRdata2, mRdata2);
    checkOutput({tag, "_imm"},    exImm,    mImm);
    checkOutput({tag, "_rs"},     exRs,     mRs);
    checkOutput({tag, "_rt"},     exRt,     mRt);
    checkOutput({tag, "_rd"},     exRd,     mRd);
    checkOutput({tag, "_scnt"},   stallCnt, sat16(mStalls));
    checkOutput({tag, "_fcnt"},   flushCnt, sat16(mFlushes));
  endtask

  task automatic applyStimulus(input logic valid, input logic [8:0] ctrl, input logic [4:0] rs,
                               input logic [4:0] rt, input logic ready, input logic flush);
    idValid  = valid;
    idCtrl   = ctrl;
    idRs     = rs;
    idRt     = rt;
    exReady  = ready;
    exFlush  = flush;
    idXflags = 6'($urandom);
    idRd     = 5'($urandom);
    idPc4    = $urandom;
    idRdata1 = $urandom;
    idRdata2 = $urandom;
    idImm    = $urandom;
  endtask

  // Checks stall_o before the edge, advances one clock, then checks every registered output.
  task automatic step(input string tag);
    #1;
    checkOutput({tag, "_stall"}, stallO, modelStall());
    @(posedge clk);
    if (!rstN) modelReset();
    else modelEdge();
    #1;
    checkAll(tag);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Reset with random inputs on every port.
    rstN = 1'b0;
    applyStimulus(1'($urandom), 9'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
    modelReset();
    #2;
    checkAll("rst");
    checkOutput("rst_stall", stallO, !exReady && !exFlush);
    step("rst_hold");
    rstN = 1'b1;

    // Pass-through of a plain R-type bundle.
    applyStimulus(1'b1, 9'h18C, 5'd1, 5'd2, 1'b1, 1'b0);
    idPc4 = 32'h0000_0010;
    step("pt");
    checkOutput("pt_ctrl", exCtrl, 9'h18C);
    checkOutput("pt_pc4", exPc4, 32'h10);
    checkOutput("pt_valid", exValid, 1'b1);

    // Load-use: lw writing r8, followed by a consumer of r8.
    applyStimulus(1'b1, 9'h1A4, 5'd3, 5'd8, 1'b1, 1'b0);
    step("lw");
    applyStimulus(1'b1, 9'h18C, 5'd8, 5'd4, 1'b1, 1'b0);
    #1;
    checkOutput("lu_stall_now", stallO, 1'b1);
    step("lu");
    checkOutput("lu_valid", exValid, 1'b0);
    checkOutput("lu_ctrl", exCtrl, 9'd0);
    checkOutput("lu_scnt", stallCnt, 16'd1);
    step("lu_load");
    checkOutput("lu_load_valid", exValid, 1'b1);
    checkOutput("lu_load_ctrl", exCtrl, 9'h18C);

    // No false hazard when the load targets r0.
    applyStimulus(1'b1, 9'h1A4, 5'd3, 5'd0, 1'b1, 1'b0);
    step("lw0");
    applyStimulus(1'b1, 9'h18C, 5'd0, 5'd0, 1'b1, 1'b0);
    #1;
    checkOutput("r0_stall", stallO, 1'b0);
    step("r0");
    checkOutput("r0_valid", exValid, 1'b1);

    // No false hazard when the producer is not a load.
    applyStimulus(1'b1, 9'h184, 5'd3, 5'd8, 1'b1, 1'b0);
    step("nolw");
    applyStimulus(1'b1, 9'h18C, 5'd8, 5'd8, 1'b1, 1'b0);
    #1;
    checkOutput("nolw_stall", stallO, 1'b0);
    step("nolw_use");
    checkOutput("nolw_valid", exValid, 1'b1);

    // Hold for three cycles with a pending load-use, then flush while still held.
    applyStimulus(1'b1, 9'h1A4, 5'd3, 5'd8, 1'b1, 1'b0);
    step("hlw");
    applyStimulus(1'b1, 9'h18C, 5'd8, 5'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("hold_stall", stallO, 1'b1);
      step("hold");
      checkOutput("hold_ctrl", exCtrl, 9'h1A4);
      checkOutput("hold_scnt", stallCnt, 16'd1);
    end
    applyStimulus(1'b1, 9'h18C, 5'd8, 5'd1, 1'b0, 1'b1);
    #1;
    checkOutput("hf_stall", stallO, 1'b0);
    step("hf");
    checkOutput("hf_valid", exValid, 1'b0);
    checkOutput("hf_fcnt", flushCnt, 16'd1);
    checkOutput("hf_scnt", stallCnt, 16'd1);

    // Randomized traffic biased toward register-index collisions and loads.
    for (int i = 0; i < 1500; i++) begin
      logic [8:0] c;
      c    = 9'($urandom);
      c[5] = ($urandom_range(0, 1) == 0);
      applyStimulus($urandom_range(0, 4) != 0, c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0);
      if (i == 700) begin
        rstN = 1'b0;
        modelReset();
        #1;
        checkAll("midrst");
        step("inrst");
        rstN = 1'b1;
      end
      step("rand");
    end

    // Flush counter saturation.
    for (int i = 0; i < 65540; i++) begin
      applyStimulus(1'($urandom), 9'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'b1);
      step("sat");
    end
    checkOutput("sat_fcnt", flushCnt, 16'hFFFF);
    applyStimulus(1'b1, 9'h18C, 5'd1, 5'd2, 1'b1, 1'b1);
    step("sat_more");
    checkOutput("sat_fcnt_hold", flushCnt, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register and load-use hazard unit between the decode stage and the execute stage of the five-stage MIPS core. It captures the 9-bit control bundle and the extended decode flags from the control decoder, together with the decode-stage datapath fields. It inserts a one-cycle bubble on a load-use hazard, clears itself on a branch/jump flush, and holds its contents when execute back-pressures. It also keeps saturating stall and flush counters for debug.

## Interface
- No parameters; data width fixed at 32, register index width fixed at 5.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_ctrl  in  9  control bundle: [8]memtoreg [7]regwrite [6]branch [5]memread [4]memwrite [3]regdst [2]alusrc [1:0]aluop.
- id_xflags  in  6  {bgtz, bne, addi, ori, andi, imm} from the decoder.
- id_valid  in  1  decode slot holds a real instruction.
- id_pc4, id_rdata1, id_rdata2, id_imm  in  32 each  PC+4, register file reads, sign-extended immediate.
- id_rs, id_rt, id_rd  in  5 each  instruction register fields.
- ex_flush  in  1  branch taken / jump resolved; kill the instruction entering execute.
- ex_ready  in  1  execute can accept a new instruction this cycle.
- ex_ctrl  out  9, ex_xflags  out  6, ex_valid  out  1  registered control toward execute.
- ex_pc4, ex_rdata1, ex_rdata2, ex_imm  out  32 each; ex_rs, ex_rt, ex_rd  out  5 each  registered datapath fields.
- stall_o  out  1  combinational: hold PC and IF/ID this cycle.
- stall_cnt, flush_cnt  out  16 each  saturating event counters.

## Operation
- The hazard condition is load_use = id_valid & ex_valid & ex_ctrl[5] & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)). The rt comparison is always made, conservatively, regardless of instruction type.
- Per-cycle action, in strict priority order:
  - Flush (ex_flush=1): ex_valid, ex_ctrl and ex_xflags are cleared to 0. Datapath fields retain their values.
  - Hold (ex_ready=0): all registers keep their values.
  - Bubble (load_use=1): ex_valid, ex_ctrl and ex_xflags are cleared to 0. Datapath fields retain their values. stall_cnt increments.
  - Load: all fields are captured from the ID inputs. ex_valid = id_valid. If id_valid=0, ex_ctrl and ex_xflags are loaded as 0.
- stall_o = (load_use | ~ex_ready) & ~ex_flush.
- flush_cnt increments on every clock edge where ex_flush=1, independent of hold.
- Both counters saturate at 16'hFFFF and never wrap.
- Invalid slots always carry an all-zero control bundle, so no regwrite, memwrite or branch can leak from a bubble.
- Effective state set: EMPTY (ex_valid=0), FULL (ex_valid=1). Transitions:
  - EMPTY to FULL: on a load with id_valid=1.
  - FULL to EMPTY: on a flush, a bubble, or a load with id_valid=0.
  - Hold keeps the current state.

## Timing
- Reset (async assert, sync to clk on release): every registered output is 0, including both counters. stall_o follows its equation; with ex_valid=0 it equals ~ex_ready & ~ex_flush.
- Latency: the ID inputs sampled at edge N appear on the ex_* outputs after edge N.
- Load-use: the stall lasts exactly 1 cycle. The bubble clears ex_ctrl[5], so load_use falls in the following cycle and the stalled decode instruction loads on the next edge.
- Simultaneous flush and load_use: flush wins; stall_o=0; stall_cnt does not increment.
- Simultaneous flush and ex_ready=0: flush still clears the slot.
- Hold with load_use=1: no bubble and no stall_cnt increment. load_use is re-evaluated each cycle.
- Reset asserted mid-stall: all outputs are 0 immediately. No counter activity until rst_n is high.

## Test plan
- Reset: rst_n=0 with random inputs -> every ex_* output is 0, stall_cnt=0, flush_cnt=0. After release, stall_o = ~ex_ready.
- Pass-through: id_valid=1, id_ctrl=9'h18C, id_pc4=32'h0000_0010, ex_ready=1 -> after one edge ex_ctrl=9'h18C, ex_pc4=32'h10, ex_valid=1, stall_o=0.
- Load-use: EX holds lw (ex_ctrl[5]=1) with ex_rt=8; ID presents id_rs=8 ->
  - stall_o=1 in that cycle.
  - After the edge: ex_valid=0, ex_ctrl=0, stall_cnt=1.
  - On the next edge the held ID instruction loads.
- No false hazard: the same setup with ex_rt=0, or ex_ctrl[5]=0 -> stall_o=0 and the ID instruction loads directly.
- Hold then flush:
  - ex_ready=0 for 3 cycles -> outputs frozen, stall_o=1.
  - Then ex_flush=1 with ex_ready=0 and load_use=1 -> ex_valid=0, stall_o=0, flush_cnt=1, stall_cnt unchanged.
- Saturation: 65540 consecutive flush cycles -> flush_cnt=16'hFFFF and it stays there. The same check applies to stall_cnt with repeated load-use pairs.
